mem_fifo_ctrl_32x64: RTL and testbench
======================================

# mem_fifo_ctrl_32x64

- Synchronous 64-bit FIFO controller that uses an external `mem_1r1w_masked_32x64` instance as its 32-entry backing store.
- Upstream, it presents valid/ready push and pop interfaces.
- Downstream, it drives the memory's W0/R0 ports and absorbs the macro's one-cycle read latency with a 2-entry output buffer, so sustained full-rate streaming works under `out_ready` backpressure.
- It sits between a producer (e.g. DMA or NoC ingress) and the memory macro, in the same clock domain.

## Interface
Parameters:
- `DATA_WIDTH`, 64, word width; must match memory width.
- `ADDR_WIDTH`, 5, memory address width; memory depth = 2^ADDR_WIDTH = 32.

Ports (clock and reset first):
- `clock`  in  1  single clock; the parent ties `R0_clk`/`W0_clk` of the memory to this clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accepted when `in_valid & in_ready` at a rising edge.
- `in_data`  in  64  push data.
- `out_valid`  out  1  head word available.
- `out_ready`  in  1  pop when `out_valid & out_ready` at a rising edge.
- `out_data`  out  64  head word; stable while `out_valid & !out_ready`.
- `count`  out  7  total words held, 0..34: SRAM entries plus in-flight read plus output buffer.
- `W0_addr`  out  5  memory write address.
- `W0_en`  out  1  memory write enable.
- `W0_data`  out  64  memory write data.
- `W0_mask`  out  8  constant 8'hFF; full-word writes only.
- `R0_addr`  out  5  memory read address.
- `R0_en`  out  1  memory read enable.
- `R0_data`  in  64  memory read data; valid the cycle after `R0_en`.

## Operation
- State registers:
  - `wptr[4:0]` and `rptr[4:0]` wrap modulo 32.
  - `sram_cnt` 0..32: entries written but not yet read-issued.
  - `inflight` 1 bit.
  - Output buffer `obuf[2]` with `obuf_cnt` 0..2, head at index 0.
- Push (`in_ready = reset_n & (sram_cnt < 32)`):
  - Accept drives `W0_en=1`, `W0_addr=wptr`, `W0_data=in_data`.
  - At the edge: `wptr++`, `sram_cnt++`.
- Read issue:
  - Condition: `sram_cnt > 0` and `obuf_cnt + inflight + (obuf pop this cycle ? -1 : 0) < 2`.
  - Action: `R0_en=1`, `R0_addr=rptr`; at the edge `rptr++`, `sram_cnt--`, `inflight` set.
  - Issue uses the registered `sram_cnt`, so a word is readable no earlier than the cycle after its write.
  - The read and write addresses can never be equal in the same cycle: equal pointers mean `sram_cnt` is 0 (no read) or 32 (no write).
- Return: while `inflight=1`, `R0_data` is appended to `obuf` at the edge and `inflight` clears, unless a new issue sets it again the same cycle.
- Pop:
  - `out_valid = obuf_cnt > 0`; `out_data = obuf[0]`.
  - Pop shifts `obuf` toward the head.
  - Pop and append in the same cycle are both honoured.
- Simultaneous push, issue, return and pop in one cycle are all legal. Counters update by net delta.
- `count = sram_cnt + inflight + obuf_cnt`. Maximum 34; in-flight plus buffered can never exceed 2.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, counters, `inflight` and `obuf_cnt` clear to 0. Buffered data is discarded.
  - While `reset_n` is low: `in_ready=0`, `out_valid=0`, `R0_en=0`, `W0_en=0`, `count=0`, `out_data=0`.
  - `W0_addr`, `R0_addr` and `W0_data` reset to 0.

## Timing
- Without bypass: a push accepted at edge k gives `out_valid=1` from cycle k+3 (write at k, issue k+1, capture k+2, visible after edge k+2).
- Throughput: 1 word/cycle sustained once primed, with `out_ready` held high.
- `in_ready` deasserts the cycle after the 32nd SRAM entry is filled, and reasserts the cycle after an issue frees a slot.
- `out_ready` is not used combinationally for `in_ready`. There is no combinational path from `in_*` to `out_*`.

## Configuration
- Macro: `MEM_FIFO_CTRL_BYPASS_EN`.
- Defined:
  - Bypass condition: `sram_cnt==0`, `inflight==0` and (`obuf_cnt<2` or pop this cycle).
  - When it holds, an accepted push writes `in_data` directly into `obuf`, with no SRAM write and `W0_en=0`.
  - Latency drops to `out_valid` at k+1.
  - Ordering is preserved because bypass only happens when the SRAM is empty and nothing is in flight.
- Undefined: all data goes through the SRAM, with k+3 latency.

## Test plan
- Reset, then a single push of 64'hDEADBEEF_00000001 -> `W0_en` pulses with `W0_addr=0`, `W0_mask=8'hFF`; `out_valid` rises at k+3 (k+1 with bypass); data matches; `count` goes 1 then 0 after pop.
- `out_ready=0`, 40 push attempts of an incrementing pattern -> exactly 34 accepted; `in_ready` low from then on; `count=34`; then drain -> values 0..33 in order.
- Streaming of 200 words with `in_valid=out_ready=1` -> after priming, one word per cycle in order; pointers wrap past 31 with no corruption.
- Random `in_valid`/`out_ready` at 50% for 5000 cycles against a scoreboard -> no loss, duplication or reorder; never `R0_en & W0_en` with equal addresses.
- Assert `reset_n` low mid-stream with `count=20` -> outputs go to their reset values immediately; after release, a push of 64'h5 is the first word popped.
- Bypass build: push into an empty FIFO -> `W0_en` stays 0 and `out_valid` appears at k+1. Push while `sram_cnt>0` -> the write goes through the SRAM and ordering holds.

Source files
------------

// File: rtl/mem_fifo_ctrl_32x64.sv
// 64-bit valid/ready FIFO controller over an external 32x64 1R1W SRAM, with a
// 2-entry output buffer that hides the SRAM read latency. Bypass: MEM_FIFO_CTRL_BYPASS_EN.
module mem_fifo_ctrl_32x64 #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH+1:0]   count,
  output logic [ADDR_WIDTH-1:0]   W0_addr,
  output logic                    W0_en,
  output logic [DATA_WIDTH-1:0]   W0_data,
  output logic [DATA_WIDTH/8-1:0] W0_mask,
  output logic [ADDR_WIDTH-1:0]   R0_addr,
  output logic                    R0_en,
  input  logic [DATA_WIDTH-1:0]   R0_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] SRAM_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_sram_cnt;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_obuf [2];
  logic [1:0]            r_obuf_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_wr;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic                  w_app;
  logic [DATA_WIDTH-1:0] w_app_data;
  logic [1:0]            w_base;
  logic [DATA_WIDTH-1:0] w_obuf_n [2];
  logic [1:0]            w_obuf_cnt_n;

  assign in_ready  = reset_n & (r_sram_cnt < SRAM_FULL);
  assign out_valid = (r_obuf_cnt != 2'd0);
  assign out_data  = r_obuf[0];
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Slots in the output path still claimed after this cycle's pop; issue only if one is free.
  assign w_occ   = {1'b0, r_obuf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_sram_cnt != '0) && (w_occ < 3'd2);

`ifdef MEM_FIFO_CTRL_BYPASS_EN
  assign w_bypass = w_push && (r_sram_cnt == '0) && !r_inflight &&
                    ((r_obuf_cnt < 2'd2) || w_pop);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr    = w_push & ~w_bypass;
  assign W0_en   = w_wr;
  assign W0_addr = r_wptr;
  assign W0_data = w_wr ? in_data : '0;
  assign W0_mask = '1;
  assign R0_en   = w_issue;
  assign R0_addr = r_rptr;

  assign count = {1'b0, r_sram_cnt} + (ADDR_WIDTH+2)'(r_inflight) + (ADDR_WIDTH+2)'(r_obuf_cnt);

  // Return and bypass are mutually exclusive: bypass requires nothing in flight.
  assign w_app      = r_inflight | w_bypass;
  assign w_app_data = w_bypass ? in_data : R0_data;
  assign w_base     = r_obuf_cnt - {1'b0, w_pop};

  always_comb begin
    w_obuf_n[0] = r_obuf[0];
    w_obuf_n[1] = r_obuf[1];
    if (w_pop) begin
      w_obuf_n[0] = r_obuf[1];
    end
    if (w_app) begin
      if (w_base == 2'd0) begin
        w_obuf_n[0] = w_app_data;
      end else begin
        w_obuf_n[1] = w_app_data;
      end
    end
    w_obuf_cnt_n = w_base + {1'b0, w_app};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
      r_obuf[0]  <= '0;
      r_obuf[1]  <= '0;
      r_obuf_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_sram_cnt <= r_sram_cnt + (ADDR_WIDTH+1)'(w_wr) - (ADDR_WIDTH+1)'(w_issue);
      r_inflight <= w_issue;
      r_obuf[0]  <= w_obuf_n[0];
      r_obuf[1]  <= w_obuf_n[1];
      r_obuf_cnt <= w_obuf_cnt_n;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl_32x64.sv
// Directed and scoreboard bench for mem_fifo_ctrl_32x64 with a behavioural 32x64 SRAM.
module tb_mem_fifo_ctrl_32x64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [6:0]  count;
  logic [4:0]  W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;
  logic [4:0]  R0_addr;
  logic        R0_en;
  logic [63:0] R0_data;

  logic [63:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int collisions = 0;
  int accepted = 0;
  int pops = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [63:0] q [$];

`ifdef MEM_FIFO_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clock = ~clock;

  mem_fifo_ctrl_32x64 #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data)
  );

  always @(posedge clock) begin
    if (W0_en) begin
      for (int b = 0; b < 8; b++) begin
        if (W0_mask[b]) mem[W0_addr][b*8 +: 8] <= W0_data[b*8 +: 8];
      end
    end
    if (R0_en) R0_data <= mem[R0_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: sample handshakes before the edge, update scoreboard after it.
  task automatic cycle();
    logic fi, fo;
    logic [63:0] di, dout;
    fi = in_valid & in_ready;
    fo = out_valid & out_ready;
    di = in_data;
    dout = out_data;
    if (R0_en && W0_en && (R0_addr == W0_addr)) collisions++;
    @(posedge clock);
    #1;
    cyc++;
    if (fo) begin
      if (q.size() == 0) chk("underflow", dout, 64'hX);
      else chk("pop_data", dout, q.pop_front());
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (fi) begin
      q.push_back(di);
      accepted++;
    end
    chk("count", 64'(count), 64'(q.size()));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int sent;
    int n;
    logic [3:0] w0e;
    logic [3:0] w0e_exp;

    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_W0_en", 64'(W0_en), 64'd0);
    chk("rst_R0_en", 64'(R0_en), 64'd0);
    reset_n = 1'b1;
    cycle();

    // Single push and its latency
    in_valid = 1'b1;
    in_data = 64'hDEADBEEF_00000001;
    #1;
    chk("single_in_ready", 64'(in_ready), 64'd1);
    chk("single_W0_en", 64'(W0_en), BYP ? 64'd0 : 64'd1);
    chk("single_W0_addr", 64'(W0_addr), 64'd0);
    chk("single_W0_mask", 64'(W0_mask), 64'hFF);
    chk("single_W0_data", W0_data, BYP ? 64'd0 : 64'hDEADBEEF_00000001);
    cycle();
    in_valid = 1'b0;
    chk("single_count1", 64'(count), 64'd1);
    lat = 0;
    while (!out_valid && lat < 8) begin
      cycle();
      lat++;
    end
    chk("single_latency", 64'(lat), BYP ? 64'd0 : 64'd2);
    chk("single_out_data", out_data, 64'hDEADBEEF_00000001);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("single_count0", 64'(count), 64'd0);
    chk("single_out_valid0", 64'(out_valid), 64'd0);

    // Fill with backpressure: 32 SRAM + 2 buffered
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data = 64'(i);
      cycle();
    end
    in_valid = 1'b0;
    chk("full_accepted", 64'(accepted), 64'd34);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd34);
    chk("full_head", q[0], 64'd0);
    chk("full_tail", q[$], 64'd33);
    cycle();
    chk("full_in_ready_hold", 64'(in_ready), 64'd0);
    drain(100);

    // Full-rate streaming across pointer wrap
    pops = 0;
    first_pop = -1;
    last_pop = -1;
    sent = 0;
    n = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 64'd1000;
    while (pops < 200 && n < 500) begin
      if (in_valid && in_ready) begin
        cycle();
        sent++;
      end else begin
        cycle();
      end
      in_data = 64'(1000 + sent);
      if (sent == 200) in_valid = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    chk("stream_pops", 64'(pops), 64'd200);
    chk("stream_rate", 64'(last_pop - first_pop), 64'd199);
    chk("stream_empty", 64'(q.size()), 64'd0);

    // Random handshakes against the scoreboard
    collisions = 0;
    for (int i = 0; i < 5000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom};
      cycle();
    end
    drain(200);
    chk("rand_collisions", 64'(collisions), 64'd0);

    // Bypass vs SRAM path selection
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 64'hA0 + 64'(i);
      #1;
      w0e[i] = W0_en;
      cycle();
    end
    in_valid = 1'b0;
    w0e_exp = BYP ? 4'b1100 : 4'b1111;
    chk("mix_W0_en", 64'(w0e), 64'(w0e_exp));
    chk("mix_head", out_data, 64'hA0);
    drain(50);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = 64'h7700 + 64'(i);
      cycle();
    end
    in_valid = 1'b0;
    chk("mid_count20", 64'(count), 64'd20);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_W0_en", 64'(W0_en), 64'd0);
    chk("mid_rst_R0_en", 64'(R0_en), 64'd0);
    q.delete();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    in_valid = 1'b1;
    in_data = 64'h5;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      cycle();
      n++;
    end
    chk("mid_first_word", out_data, 64'h5);
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
